// File: rtl/stp16_frame_scheduler.sv
// Coalesces left/right meter words into 64-bit STP16 frames, rate-limits them and re-sends
// the last frame as a keep-alive. Optional macro LAMP_TEST_EN adds an all-ones lamp-test input.
module stp16_frame_scheduler #(
  parameter int unsigned min_interval     = 2048,
  parameter int unsigned refresh_interval = 1048576,
  parameter int unsigned counter_width    = 21
) (
  input  logic        clk,
  input  logic        reset,
`ifdef LAMP_TEST_EN
  input  logic        lamp_test,
`endif
  input  logic        i_valid,
  output logic        i_ready,
  input  logic        i_is_left,
  input  logic [31:0] i_meter,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [63:0] o_data,
  output logic        o_is_refresh
);

  localparam logic [counter_width-1:0] MIN_CNT     = counter_width'(min_interval);
  localparam logic [counter_width-1:0] REFRESH_CNT = counter_width'(refresh_interval);
  localparam logic [counter_width-1:0] CNT_ONE     = counter_width'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic                     i_ready_q, i_ready_d;
  logic                     o_valid_q, o_valid_d;
  logic [63:0]              o_data_q, o_data_d;
  logic                     o_is_refresh_q, o_is_refresh_d;
  logic [31:0]              shadow_l_q, shadow_l_d;
  logic [31:0]              shadow_r_q, shadow_r_d;
  logic                     dirty_q, dirty_d;
  logic [counter_width-1:0] cnt_q, cnt_d;
  logic                     wr_s;
  logic                     accept_s;
`ifdef LAMP_TEST_EN
  logic                     lamp_prev_q, lamp_prev_d;
`endif

  // Right channel LEDs are physically wired in the opposite order.
  function automatic logic [31:0] reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) begin
      r[k] = v[31-k];
    end
    return r;
  endfunction

  assign wr_s     = i_valid && i_ready_q;
  assign accept_s = o_valid_q && o_ready;

  always_comb begin
    state_d        = state_q;
    i_ready_d      = 1'b1;
    o_valid_d      = o_valid_q;
    o_data_d       = o_data_q;
    o_is_refresh_d = o_is_refresh_q;
    shadow_l_d     = shadow_l_q;
    shadow_r_d     = shadow_r_q;
    dirty_d        = dirty_q;
`ifdef LAMP_TEST_EN
    lamp_prev_d    = lamp_test;
`endif

    if (wr_s) begin
      if (i_is_left) begin
        shadow_l_d = i_meter;
      end else begin
        shadow_r_d = reverse32(i_meter);
      end
    end

    if (accept_s) begin
      cnt_d = '0;
    end else if (cnt_q >= REFRESH_CNT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

`ifdef LAMP_TEST_EN
    // Leaving lamp test must repaint the real meter even if nothing new arrived.
    if (lamp_prev_q && !lamp_test) begin
      dirty_d = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
`ifdef LAMP_TEST_EN
        if (lamp_test) begin
          if (cnt_q >= MIN_CNT) begin
            state_d        = SEND;
            o_valid_d      = 1'b1;
            o_data_d       = 64'hFFFF_FFFF_FFFF_FFFF;
            o_is_refresh_d = 1'b0;
          end
        end else
`endif
        if (dirty_q && (cnt_q >= MIN_CNT)) begin
          state_d        = SEND;
          o_valid_d      = 1'b1;
          o_data_d       = {shadow_l_q, shadow_r_q};
          o_is_refresh_d = 1'b0;
          dirty_d        = 1'b0;
        end else if (!dirty_q && (cnt_q >= REFRESH_CNT)) begin
          state_d        = SEND;
          o_valid_d      = 1'b1;
          o_data_d       = {shadow_l_q, shadow_r_q};
          o_is_refresh_d = 1'b1;
          dirty_d        = 1'b0;
        end
      end
      SEND: begin
        if (accept_s) begin
          state_d   = IDLE;
          o_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        o_valid_d = 1'b0;
      end
    endcase

    // A word arriving on the latch cycle must not be lost by the dirty clear.
    if (wr_s) begin
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      i_ready_q      <= 1'b0;
      o_valid_q      <= 1'b0;
      o_data_q       <= 64'h0;
      o_is_refresh_q <= 1'b0;
      shadow_l_q     <= 32'h0;
      shadow_r_q     <= 32'h0;
      dirty_q        <= 1'b0;
      cnt_q          <= '0;
`ifdef LAMP_TEST_EN
      lamp_prev_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      i_ready_q      <= i_ready_d;
      o_valid_q      <= o_valid_d;
      o_data_q       <= o_data_d;
      o_is_refresh_q <= o_is_refresh_d;
      shadow_l_q     <= shadow_l_d;
      shadow_r_q     <= shadow_r_d;
      dirty_q        <= dirty_d;
      cnt_q          <= cnt_d;
`ifdef LAMP_TEST_EN
      lamp_prev_q    <= lamp_prev_d;
`endif
    end
  end

  assign i_ready      = i_ready_q;
  assign o_valid      = o_valid_q;
  assign o_data       = o_data_q;
  assign o_is_refresh = o_is_refresh_q;

endmodule
